// File: rtl/finish_pkg.sv
// Shared types and width helpers for the finish-message queue.
package finish_pkg;

    localparam int unsigned DEF_XACT_W = 2;
    localparam int unsigned DEF_MGR_W  = 1;

    typedef struct packed {
        logic [DEF_XACT_W-1:0] manager_xact_id;
        logic [DEF_MGR_W-1:0]  manager_id;
    } finish_t;

    // Ceiling log2; clog2(0) = clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy width: must hold 0..depth inclusive
    function automatic int unsigned cnt_w(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    // Pointer width, at least one bit so DEPTH==1 still has a legal vector
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/finish_queue_flex_wrap_ptr.sv
// Modulo-DEPTH pointer with explicit wrap, for non-power-of-2 depths.
module wrap_ptr
    import finish_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // Pointer register: clear beats increment; DEPTH==1 naturally stays at 0
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/finish_queue_flex.sv
// Finish-message FIFO with flow/pipe bypass, flush and almost-full watermark.
module finish_queue_flex
    import finish_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned XACT_W    = DEF_XACT_W,
    parameter int unsigned MGR_W     = DEF_MGR_W,
    parameter int unsigned FLOW      = 0,
    parameter int unsigned PIPE      = 0,
    parameter int unsigned AF_THRESH = DEPTH,
    localparam int unsigned CNT_W    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    output logic              io_enq_ready,
    input  logic              io_enq_valid,
    input  logic [XACT_W-1:0] io_enq_bits_manager_xact_id,
    input  logic [MGR_W-1:0]  io_enq_bits_manager_id,
    input  logic              io_deq_ready,
    output logic              io_deq_valid,
    output logic [XACT_W-1:0] io_deq_bits_manager_xact_id,
    output logic [MGR_W-1:0]  io_deq_bits_manager_id,
    output logic [CNT_W-1:0]  io_count,
    output logic              io_almost_full
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned ENT_W = XACT_W + MGR_W;
    localparam int unsigned EXT_W = CNT_W + 1;
    localparam logic FLOW_EN = (FLOW != 0);
    localparam logic PIPE_EN = (PIPE != 0);

    logic [ENT_W-1:0] ram [DEPTH];
    logic [PTR_W-1:0] enq_ptr;
    logic [PTR_W-1:0] deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             do_enq;
    logic             do_deq;
    logic             bypass_fire;
    logic             enq_inc;
    logic             deq_inc;
    logic [ENT_W-1:0] ram_rd;
    logic [EXT_W-1:0] diff_raw;
    logic [EXT_W-1:0] diff;

    wrap_ptr #(.DEPTH(DEPTH)) u_enq_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (enq_inc),
        .ptr   (enq_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_deq_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (deq_inc),
        .ptr   (deq_ptr)
    );

    // Handshakes, bypass decode, occupancy and head payload
    always_comb begin
        ptr_match    = (enq_ptr == deq_ptr);
        empty        = ptr_match && !maybe_full;
        full         = ptr_match && maybe_full;
        io_enq_ready = !full || (PIPE_EN && io_deq_ready);
        io_deq_valid = !empty || (FLOW_EN && io_enq_valid);
        do_enq       = io_enq_valid && io_enq_ready;
        do_deq       = io_deq_valid && io_deq_ready;
        // Empty flow queue handing an entry straight through touches no state
        bypass_fire  = FLOW_EN && empty && do_enq && do_deq;
        enq_inc      = do_enq && !bypass_fire;
        deq_inc      = do_deq && !bypass_fire;

        ram_rd = ram[deq_ptr];
        if (FLOW_EN && empty) begin
            io_deq_bits_manager_xact_id = io_enq_bits_manager_xact_id;
            io_deq_bits_manager_id      = io_enq_bits_manager_id;
        end else begin
            io_deq_bits_manager_xact_id = ram_rd[ENT_W-1:MGR_W];
            io_deq_bits_manager_id      = ram_rd[MGR_W-1:0];
        end

        diff_raw = EXT_W'(enq_ptr) + EXT_W'(DEPTH) - EXT_W'(deq_ptr);
        diff     = (diff_raw >= EXT_W'(DEPTH)) ? diff_raw - EXT_W'(DEPTH) : diff_raw;
        io_count = full ? CNT_W'(DEPTH) : CNT_W'(diff);
        io_almost_full = (EXT_W'(io_count) >= EXT_W'(AF_THRESH));
    end

    // Full/empty disambiguation when pointers coincide
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            maybe_full <= 1'b0;
        end else if (enq_inc != deq_inc) begin
            maybe_full <= enq_inc;
        end
    end

    // Entry storage, intentionally not cleared by reset or flush
    always_ff @(posedge clk) begin
        if (enq_inc && !reset && !flush) begin
            ram[enq_ptr] <= {io_enq_bits_manager_xact_id, io_enq_bits_manager_id};
        end
    end

endmodule

// File: tb/tb_finish_queue_flex.sv
// Directed bench: DEPTH=3 basic queue, DEPTH=2 flow queue, DEPTH=2 pipe queue.
module tb_finish_queue_flex;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    // DEPTH=3 plain queue
    logic       a_flush, a_enq_ready, a_enq_valid, a_deq_ready, a_deq_valid, a_af;
    logic [1:0] a_enq_x, a_deq_x, a_count;
    logic       a_enq_m, a_deq_m;
    // DEPTH=2 flow queue
    logic       f_flush, f_enq_ready, f_enq_valid, f_deq_ready, f_deq_valid, f_af;
    logic [1:0] f_enq_x, f_deq_x, f_count;
    logic       f_enq_m, f_deq_m;
    // DEPTH=2 pipe queue
    logic       p_flush, p_enq_ready, p_enq_valid, p_deq_ready, p_deq_valid, p_af;
    logic [1:0] p_enq_x, p_deq_x, p_count;
    logic       p_enq_m, p_deq_m;

    finish_queue_flex #(.DEPTH(3)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .io_enq_ready(a_enq_ready), .io_enq_valid(a_enq_valid),
        .io_enq_bits_manager_xact_id(a_enq_x), .io_enq_bits_manager_id(a_enq_m),
        .io_deq_ready(a_deq_ready), .io_deq_valid(a_deq_valid),
        .io_deq_bits_manager_xact_id(a_deq_x), .io_deq_bits_manager_id(a_deq_m),
        .io_count(a_count), .io_almost_full(a_af)
    );

    finish_queue_flex #(.DEPTH(2), .FLOW(1)) u_f (
        .clk(clk), .reset(reset), .flush(f_flush),
        .io_enq_ready(f_enq_ready), .io_enq_valid(f_enq_valid),
        .io_enq_bits_manager_xact_id(f_enq_x), .io_enq_bits_manager_id(f_enq_m),
        .io_deq_ready(f_deq_ready), .io_deq_valid(f_deq_valid),
        .io_deq_bits_manager_xact_id(f_deq_x), .io_deq_bits_manager_id(f_deq_m),
        .io_count(f_count), .io_almost_full(f_af)
    );

    finish_queue_flex #(.DEPTH(2), .PIPE(1)) u_p (
        .clk(clk), .reset(reset), .flush(p_flush),
        .io_enq_ready(p_enq_ready), .io_enq_valid(p_enq_valid),
        .io_enq_bits_manager_xact_id(p_enq_x), .io_enq_bits_manager_id(p_enq_m),
        .io_deq_ready(p_deq_ready), .io_deq_valid(p_deq_valid),
        .io_deq_bits_manager_xact_id(p_deq_x), .io_deq_bits_manager_id(p_deq_m),
        .io_count(p_count), .io_almost_full(p_af)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++; if (a_count !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", a_count); end
        n_cmp++; if (a_enq_ready !== 1'b1) begin n_err++; $display("FAIL reset_enq_ready: got %b want 1", a_enq_ready); end
        n_cmp++; if (a_deq_valid !== 1'b0) begin n_err++; $display("FAIL reset_deq_valid: got %b want 0", a_deq_valid); end
        n_cmp++; if (a_af !== 1'b0) begin n_err++; $display("FAIL reset_af: got %b want 0", a_af); end
        n_cmp++; if (p_count !== 2'd0 || p_enq_ready !== 1'b1) begin n_err++; $display("FAIL reset_pipe: count %0d rdy %b want 0 1", p_count, p_enq_ready); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 3; i++) begin
            a_enq_valid = 1'b1; a_enq_x = 2'(i); a_enq_m = 1'(i % 2); a_deq_ready = 1'b0;
            @(negedge clk); #1;
            n_cmp++; if (a_count !== 2'(i)) begin n_err++; $display("FAIL fill_count%0d: got %0d want %0d", i, a_count, i); end
            n_cmp++; if (a_enq_ready !== (i < 3)) begin n_err++; $display("FAIL fill_enq_ready%0d: got %b want %b", i, a_enq_ready, i < 3); end
            n_cmp++; if (a_af !== (i == 3)) begin n_err++; $display("FAIL fill_af%0d: got %b want %b", i, a_af, i == 3); end
        end
        // Enqueue attempt while full must be dropped
        a_enq_x = 2'd0;
        @(negedge clk); #1;
        a_enq_valid = 1'b0;
        n_cmp++; if (a_count !== 2'd3) begin n_err++; $display("FAIL full_ignore_count: got %0d want 3", a_count); end
        for (int i = 1; i <= 3; i++) begin
            a_deq_ready = 1'b1; #1;
            n_cmp++; if (a_deq_valid !== 1'b1 || a_deq_x !== 2'(i) || a_deq_m !== 1'(i % 2)) begin
                n_err++; $display("FAIL drain_head%0d: got v%b x%0d m%0d want v1 x%0d m%0d", i, a_deq_valid, a_deq_x, a_deq_m, i, i % 2);
            end
            @(negedge clk); #1;
            n_cmp++; if (a_count !== 2'(3 - i)) begin n_err++; $display("FAIL drain_count%0d: got %0d want %0d", i, a_count, 3 - i); end
        end
        a_deq_ready = 1'b0; #1;
        n_cmp++; if (a_deq_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", a_deq_valid); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 10; k++) begin
            a_enq_valid = 1'b1; a_enq_x = 2'(k % 4); a_enq_m = 1'(k % 2); a_deq_ready = 1'b0;
            @(negedge clk); #1;
            a_enq_valid = 1'b0;
            n_cmp++; if (a_count !== 2'd1) begin n_err++; $display("FAIL wrap_count_enq%0d: got %0d want 1", k, a_count); end
            a_deq_ready = 1'b1; #1;
            n_cmp++; if (a_deq_x !== 2'(k % 4) || a_deq_m !== 1'(k % 2)) begin
                n_err++; $display("FAIL wrap_head%0d: got x%0d m%0d want x%0d m%0d", k, a_deq_x, a_deq_m, k % 4, k % 2);
            end
            @(negedge clk); #1;
            a_deq_ready = 1'b0;
            n_cmp++; if (a_count !== 2'd0) begin n_err++; $display("FAIL wrap_count_deq%0d: got %0d want 0", k, a_count); end
        end
    endtask

    task automatic test_flow();
        @(negedge clk);
        f_enq_valid = 1'b1; f_enq_x = 2'd2; f_enq_m = 1'b1; f_deq_ready = 1'b1; #1;
        n_cmp++; if (f_deq_valid !== 1'b1 || f_deq_x !== 2'd2 || f_deq_m !== 1'b1) begin
            n_err++; $display("FAIL flow_bypass: got v%b x%0d m%0d want v1 x2 m1", f_deq_valid, f_deq_x, f_deq_m);
        end
        @(negedge clk);
        f_enq_valid = 1'b0; f_deq_ready = 1'b0; #1;
        n_cmp++; if (f_count !== 2'd0 || f_deq_valid !== 1'b0) begin
            n_err++; $display("FAIL flow_after: got count %0d v%b want 0 0", f_count, f_deq_valid);
        end
        // Without a ready consumer the entry is stored normally
        f_enq_valid = 1'b1; f_enq_x = 2'd3; f_enq_m = 1'b0;
        @(negedge clk);
        f_enq_valid = 1'b0; #1;
        n_cmp++; if (f_count !== 2'd1 || f_deq_x !== 2'd3) begin
            n_err++; $display("FAIL flow_store: got count %0d x%0d want 1 x3", f_count, f_deq_x);
        end
        f_deq_ready = 1'b1;
        @(negedge clk);
        f_deq_ready = 1'b0; #1;
        n_cmp++; if (f_count !== 2'd0) begin n_err++; $display("FAIL flow_drain: got %0d want 0", f_count); end
    endtask

    task automatic test_pipe();
        for (int i = 1; i <= 2; i++) begin
            p_enq_valid = 1'b1; p_enq_x = 2'(i); p_enq_m = 1'b0; p_deq_ready = 1'b0;
            @(negedge clk);
        end
        #1;
        n_cmp++; if (p_count !== 2'd2 || p_enq_ready !== 1'b0 || p_af !== 1'b1) begin
            n_err++; $display("FAIL pipe_full: got count %0d rdy %b af %b want 2 0 1", p_count, p_enq_ready, p_af);
        end
        p_enq_x = 2'd3; p_enq_m = 1'b1; p_deq_ready = 1'b1; #1;
        n_cmp++; if (p_enq_ready !== 1'b1 || p_deq_x !== 2'd1) begin
            n_err++; $display("FAIL pipe_replace: got rdy %b x%0d want 1 x1", p_enq_ready, p_deq_x);
        end
        @(negedge clk);
        p_enq_valid = 1'b0; p_deq_ready = 1'b0; #1;
        n_cmp++; if (p_count !== 2'd2 || p_deq_x !== 2'd2) begin
            n_err++; $display("FAIL pipe_after: got count %0d x%0d want 2 x2", p_count, p_deq_x);
        end
        p_deq_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (p_count !== 2'd1 || p_deq_x !== 2'd3 || p_deq_m !== 1'b1) begin
            n_err++; $display("FAIL pipe_tail: got count %0d x%0d m%0d want 1 x3 m1", p_count, p_deq_x, p_deq_m);
        end
        @(negedge clk);
        p_deq_ready = 1'b0; #1;
        n_cmp++; if (p_count !== 2'd0) begin n_err++; $display("FAIL pipe_drain: got %0d want 0", p_count); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            a_enq_valid = 1'b1; a_enq_x = 2'(i); a_enq_m = 1'b0; a_deq_ready = 1'b0;
            @(negedge clk);
        end
        a_flush = 1'b1; a_enq_x = 2'd0;
        @(negedge clk);
        a_flush = 1'b0; a_enq_valid = 1'b0; #1;
        n_cmp++; if (a_count !== 2'd0 || a_deq_valid !== 1'b0 || a_enq_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_state: got count %0d v%b rdy %b want 0 0 1", a_count, a_deq_valid, a_enq_ready);
        end
        a_enq_valid = 1'b1; a_enq_x = 2'd2; a_enq_m = 1'b1;
        @(negedge clk);
        a_enq_valid = 1'b0; #1;
        n_cmp++; if (a_count !== 2'd1 || a_deq_x !== 2'd2 || a_deq_m !== 1'b1) begin
            n_err++; $display("FAIL flush_reuse: got count %0d x%0d m%0d want 1 x2 m1", a_count, a_deq_x, a_deq_m);
        end
        a_deq_ready = 1'b1;
        @(negedge clk);
        a_deq_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 1; i <= 2; i++) begin
            a_enq_valid = 1'b1; a_enq_x = 2'(i); a_enq_m = 1'b0;
            @(negedge clk);
        end
        a_enq_valid = 1'b0; #1;
        n_cmp++; if (a_count !== 2'd2) begin n_err++; $display("FAIL pre_reset_count: got %0d want 2", a_count); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; #1;
        n_cmp++; if (a_count !== 2'd0 || a_deq_valid !== 1'b0 || a_enq_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_reset: got count %0d v%b rdy %b want 0 0 1", a_count, a_deq_valid, a_enq_ready);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        clk = 1'b0; reset = 1'b1;
        a_flush = 0; a_enq_valid = 0; a_enq_x = 0; a_enq_m = 0; a_deq_ready = 0;
        f_flush = 0; f_enq_valid = 0; f_enq_x = 0; f_enq_m = 0; f_deq_ready = 0;
        p_flush = 0; p_enq_valid = 0; p_enq_x = 0; p_enq_m = 0; p_deq_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_flow();
        test_pipe();
        test_flush();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
